byte_load_unit: RTL

- Sequential byte-fetch stage directly upstream of the 8-to-16 zero extender in the processor datapath.
- On a load-byte request it fetches one 16-bit word from data memory over a req/ack handshake and selects the addressed byte.
- It presents that byte on ld_byte, which feeds the extender's 8-bit input; the 16-bit result goes to the register file write port.

---
 rtl/byte_load_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/byte_load_unit.sv
// Byte-fetch stage: reads one 16-bit word over a req/ack handshake and returns the addressed byte.
// Optional abort on a missing ack is enabled with `define LD_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module byte_load_unit #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [7:0]        ld_byte,
    output logic              ld_err,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    // Handshake: mem_req rises with the latched word address and both stay stable
    // until the first edge with mem_ack=1; acks outside REQ are ignored.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range 1..65535");
    end

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-2:0] mem_addr_q, mem_addr_d;
    logic [7:0]        ld_byte_q, ld_byte_d;
    logic              ld_done_q, ld_done_d;
    logic              ld_err_q, ld_err_d;
    logic              ld_busy_q, ld_busy_d;
    logic              sel_q, sel_d;

`ifdef LD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ld_byte_d  = ld_byte_q;
        sel_d      = sel_q;
        ld_done_d  = 1'b0;
        ld_err_d   = 1'b0;
`ifdef LD_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_req) begin
                    mem_addr_d = ld_addr[ADDR_W-1:1];
                    sel_d      = ld_addr[0];
                    mem_req_d  = 1'b1;
                    state_d    = S_REQ;
`ifdef LD_TIMEOUT_EN
                    cnt_d      = 16'd0;
`endif
                end
            end
            S_REQ: begin
                // An ack on the limit edge still wins over the abort.
                if (mem_ack) begin
                    ld_byte_d = sel_q ? mem_rdata[15:8] : mem_rdata[7:0];
                    mem_req_d = 1'b0;
                    ld_done_d = 1'b1;
                    state_d   = S_DONE;
                end
`ifdef LD_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    ld_done_d = 1'b1;
                    ld_err_d  = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        ld_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ld_byte_q  <= 8'h00;
            ld_done_q  <= 1'b0;
            ld_err_q   <= 1'b0;
            ld_busy_q  <= 1'b0;
            sel_q      <= 1'b0;
`ifdef LD_TIMEOUT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ld_byte_q  <= ld_byte_d;
            ld_done_q  <= ld_done_d;
            ld_err_q   <= ld_err_d;
            ld_busy_q  <= ld_busy_d;
            sel_q      <= sel_d;
`ifdef LD_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign ld_busy  = ld_busy_q;
    assign ld_done  = ld_done_q;
    assign ld_byte  = ld_byte_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef LD_TIMEOUT_EN
    assign ld_err = ld_err_q;
`else
    logic unused_err;
    assign unused_err = ld_err_q;
    assign ld_err     = 1'b0;
`endif

endmodule
